// File: rtl/uart_rx_deserializer.sv
// UART receive front end: RX synchroniser, oversampled frame recovery with 3-sample majority vote,
// parity/stop checking and a single-byte holding register. Optional: UART_RX_BREAK_DETECT_EN.
module uart_rx_deserializer #(
    parameter int SYNC_STAGES = 2,
    parameter int OVS_RATE    = 16
) (
    input  logic       PCLK,
    input  logic       PRESETN,
    input  logic       BAUD_TICK,
    input  logic       RX,
    input  logic       BIT8,
    input  logic       PARITY_EN,
    input  logic       ODD_N_EVEN,
    input  logic       RD_ACK,
    output logic [7:0] DATA_OUT,
    output logic       RXRDY,
    output logic       PARITY_ERR,
    output logic       FRAMING_ERR,
    output logic       OVERFLOW,
    output logic       BREAK_DET
);

    localparam int CNT_W = $clog2(OVS_RATE);
    localparam logic [CNT_W-1:0] SAMP_A = CNT_W'(OVS_RATE / 2 - 2);
    localparam logic [CNT_W-1:0] SAMP_B = CNT_W'(OVS_RATE / 2 - 1);
    localparam logic [CNT_W-1:0] SAMP_C = CNT_W'(OVS_RATE / 2);
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(OVS_RATE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DONE,
        S_BREAK
    } state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic parity_mismatch(input logic [7:0] data, input logic pbit,
                                             input logic odd);
        return ((^data) ^ pbit) != odd;
    endfunction

    state_t                 state;
    state_t                 state_nxt;
    logic [SYNC_STAGES-1:0] rx_sync;
    logic                   rx_s;
    logic [CNT_W-1:0]       tick_cnt;
    logic [CNT_W-1:0]       cnt_now;
    logic [2:0]             bit_idx;
    logic                   samp_a;
    logic                   samp_b;
    logic                   maj;
    logic                   decide;
    logic                   last_data;
    logic                   in_frame;
    logic [7:0]             shreg;
    logic [7:0]             data_bits;
    logic                   bit8_q;
    logic                   par_en_q;
    logic                   odd_q;
    logic                   par_bit;
    logic                   stop_bit;
    logic                   frame_par_err;
    logic                   is_break;
    logic                   ack_eff;

    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            rx_sync <= '1;
        end else begin
            rx_sync <= {rx_sync[SYNC_STAGES-2:0], RX};
        end
    end

    assign rx_s = rx_sync[SYNC_STAGES-1];

    // cnt_now is the oversample index of the tick arriving this cycle; index 0 is the start-detect tick.
    assign cnt_now   = (tick_cnt == LAST) ? '0 : tick_cnt + 1'b1;
    assign decide    = BAUD_TICK && (cnt_now == SAMP_C);
    assign maj       = majority3(samp_a, samp_b, rx_s);
    assign last_data = (bit_idx == (bit8_q ? 3'd7 : 3'd6));
    assign in_frame  = (state == S_START) || (state == S_DATA) ||
                       (state == S_PARITY) || (state == S_STOP);
    assign data_bits = bit8_q ? shreg : {1'b0, shreg[6:0]};
    assign frame_par_err = par_en_q && parity_mismatch(data_bits, par_bit, odd_q);

    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (BAUD_TICK && !rx_s) state_nxt = S_START;
            S_START:  if (decide) state_nxt = maj ? S_IDLE : S_DATA;
            S_DATA:   if (decide && last_data) state_nxt = par_en_q ? S_PARITY : S_STOP;
            S_PARITY: if (decide) state_nxt = S_STOP;
            S_STOP:   if (decide) state_nxt = S_DONE;
            S_DONE:   state_nxt = is_break ? S_BREAK : S_IDLE;
            S_BREAK:  if (rx_s) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            tick_cnt <= '0;
            bit_idx  <= '0;
            samp_a   <= 1'b1;
            samp_b   <= 1'b1;
            shreg    <= '0;
            bit8_q   <= 1'b0;
            par_en_q <= 1'b0;
            odd_q    <= 1'b0;
            par_bit  <= 1'b0;
            stop_bit <= 1'b0;
        end else if (state == S_IDLE) begin
            // Frame format is frozen at start detect so mid-frame config writes cannot corrupt it.
            if (BAUD_TICK && !rx_s) begin
                tick_cnt <= '0;
                bit_idx  <= '0;
                shreg    <= '0;
                bit8_q   <= BIT8;
                par_en_q <= PARITY_EN;
                odd_q    <= ODD_N_EVEN;
            end
        end else if (in_frame && BAUD_TICK) begin
            tick_cnt <= cnt_now;
            if (cnt_now == SAMP_A) samp_a <= rx_s;
            if (cnt_now == SAMP_B) samp_b <= rx_s;
            if (decide) begin
                case (state)
                    S_DATA: begin
                        shreg[bit_idx] <= maj;
                        bit_idx        <= bit_idx + 3'd1;
                    end
                    S_PARITY: par_bit  <= maj;
                    S_STOP:   stop_bit <= maj;
                    default:  ;
                endcase
            end
        end
    end

`ifdef UART_RX_BREAK_DETECT_EN
    logic break_q;

    assign is_break = (data_bits == 8'h00) && !(par_en_q && par_bit) && !stop_bit;

    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            break_q <= 1'b0;
        end else if ((state == S_DONE) && is_break) begin
            break_q <= 1'b1;
        end else if (ack_eff) begin
            break_q <= 1'b0;
        end
    end

    assign BREAK_DET = break_q;
`else
    assign is_break  = 1'b0;
    assign BREAK_DET = 1'b0;
`endif

    assign ack_eff = RD_ACK && (RXRDY || BREAK_DET);

    // An ack landing in the DONE cycle frees the holder, so the new byte loads instead of overflowing.
    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            DATA_OUT    <= '0;
            RXRDY       <= 1'b0;
            PARITY_ERR  <= 1'b0;
            FRAMING_ERR <= 1'b0;
            OVERFLOW    <= 1'b0;
        end else begin
            if (ack_eff) begin
                RXRDY       <= 1'b0;
                PARITY_ERR  <= 1'b0;
                FRAMING_ERR <= 1'b0;
                OVERFLOW    <= 1'b0;
            end
            if (state == S_DONE) begin
                if (is_break) begin
                    FRAMING_ERR <= 1'b1;
                end else if (!RXRDY || ack_eff) begin
                    DATA_OUT    <= data_bits;
                    PARITY_ERR  <= frame_par_err;
                    FRAMING_ERR <= !stop_bit;
                    RXRDY       <= 1'b1;
                end else begin
                    OVERFLOW <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: frames are driven bit-by-bit on RX and a
// frame-level model of the holding register is compared against the outputs every cycle.
module tb_uart_rx_deserializer;

    localparam int TICK_DIV = 4;
    localparam int BIT_CYC  = 16 * TICK_DIV;

    logic       PCLK = 1'b0;
    logic       PRESETN;
    logic       BAUD_TICK;
    logic       RX;
    logic       BIT8;
    logic       PARITY_EN;
    logic       ODD_N_EVEN;
    logic       RD_ACK;
    logic [7:0] DATA_OUT;
    logic       RXRDY;
    logic       PARITY_ERR;
    logic       FRAMING_ERR;
    logic       OVERFLOW;
    logic       BREAK_DET;

    int         n_checks = 0;
    int         n_fail   = 0;
    bit         chk_en   = 1'b0;

    logic [7:0] exp_data;
    bit         exp_rdy;
    bit         exp_pe;
    bit         exp_fe;
    bit         exp_ov;
    bit         exp_brk;

    uart_rx_deserializer dut (
        .PCLK       (PCLK),
        .PRESETN    (PRESETN),
        .BAUD_TICK  (BAUD_TICK),
        .RX         (RX),
        .BIT8       (BIT8),
        .PARITY_EN  (PARITY_EN),
        .ODD_N_EVEN (ODD_N_EVEN),
        .RD_ACK     (RD_ACK),
        .DATA_OUT   (DATA_OUT),
        .RXRDY      (RXRDY),
        .PARITY_ERR (PARITY_ERR),
        .FRAMING_ERR(FRAMING_ERR),
        .OVERFLOW   (OVERFLOW),
        .BREAK_DET  (BREAK_DET)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        BAUD_TICK = 1'b0;
        forever begin
            repeat (TICK_DIV - 1) @(negedge PCLK);
            BAUD_TICK = 1'b1;
            @(negedge PCLK);
            BAUD_TICK = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no end of test, required end");
        $fatal(1);
    end

    task automatic model_reset();
        exp_data = 8'h00;
        exp_rdy  = 1'b0;
        exp_pe   = 1'b0;
        exp_fe   = 1'b0;
        exp_ov   = 1'b0;
        exp_brk  = 1'b0;
    endtask

    task automatic model_frame(input logic [7:0] d, input bit b8, input bit pen, input bit odd,
                               input bit pbit, input bit stopb);
        logic [7:0] db;
        int         ones;
        bit         brk;
        db   = b8 ? d : {1'b0, d[6:0]};
        ones = $countones(db) + ((pen && pbit) ? 1 : 0);
`ifdef UART_RX_BREAK_DETECT_EN
        brk  = (db == 8'h00) && !(pen && pbit) && !stopb;
`else
        brk  = 1'b0;
`endif
        if (brk) begin
            exp_brk = 1'b1;
            exp_fe  = 1'b1;
        end else if (!exp_rdy) begin
            exp_data = db;
            exp_pe   = pen && (((ones % 2) == 1) != odd);
            exp_fe   = !stopb;
            exp_rdy  = 1'b1;
        end else begin
            exp_ov = 1'b1;
        end
    endtask

    task automatic model_ack();
        if (exp_rdy || exp_brk) begin
            exp_rdy = 1'b0;
            exp_pe  = 1'b0;
            exp_fe  = 1'b0;
            exp_ov  = 1'b0;
            exp_brk = 1'b0;
        end
    endtask

    always @(negedge PCLK) begin
        if (chk_en) begin
            n_checks++;
            if ({DATA_OUT, RXRDY, PARITY_ERR, FRAMING_ERR, OVERFLOW, BREAK_DET} !==
                {exp_data, exp_rdy, exp_pe, exp_fe, exp_ov, exp_brk}) begin
                n_fail++;
                $display("FAIL cycle_compare t=%0t: got data=%h rdy=%b pe=%b fe=%b ov=%b brk=%b, required data=%h rdy=%b pe=%b fe=%b ov=%b brk=%b",
                         $time, DATA_OUT, RXRDY, PARITY_ERR, FRAMING_ERR, OVERFLOW, BREAK_DET,
                         exp_data, exp_rdy, exp_pe, exp_fe, exp_ov, exp_brk);
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    task automatic drive_bit(input logic b);
        RX = b;
        wait_cyc(BIT_CYC);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit b8, input bit pen, input bit odd,
                              input bit pbit, input bit stopb);
        BIT8       = b8;
        PARITY_EN  = pen;
        ODD_N_EVEN = odd;
        drive_bit(1'b0);
        for (int i = 0; i < (b8 ? 8 : 7); i++) drive_bit(d[i]);
        if (pen) drive_bit(pbit);
        chk_en = 1'b0;
        drive_bit(stopb);
        RX = 1'b1;
        wait_cyc(16);
        model_frame(d, b8, pen, odd, pbit, stopb);
        chk_en = 1'b1;
    endtask

    task automatic do_ack();
        RD_ACK = 1'b1;
        chk_en = 1'b0;
        wait_cyc(1);
        RD_ACK = 1'b0;
        model_ack();
        chk_en = 1'b1;
        wait_cyc(2);
    endtask

    initial begin
        PRESETN    = 1'b0;
        RX         = 1'b1;
        RD_ACK     = 1'b0;
        BIT8       = 1'b1;
        PARITY_EN  = 1'b0;
        ODD_N_EVEN = 1'b0;
        model_reset();
        wait_cyc(4);
        check("reset_data", DATA_OUT, 8'h00);
        check("reset_rxrdy", RXRDY, 8'h00);
        check("reset_flags", {PARITY_ERR, FRAMING_ERR, OVERFLOW, BREAK_DET}, 8'h00);
        PRESETN = 1'b1;
        chk_en  = 1'b1;
        wait_cyc(8);

        send_frame(8'hA5, 1, 0, 0, 0, 1);
        check("8n1_a5_data", DATA_OUT, 8'hA5);
        check("8n1_a5_rxrdy", RXRDY, 8'h01);
        check("8n1_a5_errors", {PARITY_ERR, FRAMING_ERR, OVERFLOW}, 8'h00);
        do_ack();
        check("8n1_a5_ack_rxrdy", RXRDY, 8'h00);
        do_ack();
        check("idle_ack_no_effect", {RXRDY, OVERFLOW}, 8'h00);

        send_frame(8'h35, 0, 1, 0, 1, 1);
        check("7e1_35_data", DATA_OUT, 8'h35);
        check("7e1_35_parity_err", PARITY_ERR, 8'h01);
        do_ack();
        check("7e1_ack_parity_err", PARITY_ERR, 8'h00);

        send_frame(8'h0F, 1, 1, 1, 1, 1);
        check("8o1_0f_data", DATA_OUT, 8'h0F);
        check("8o1_0f_parity_ok", PARITY_ERR, 8'h00);
        do_ack();

        send_frame(8'hB5, 0, 0, 0, 0, 1);
        check("7n1_bit7_zero", DATA_OUT, 8'h35);
        do_ack();

        send_frame(8'h5A, 1, 0, 0, 0, 1);
        send_frame(8'h3C, 1, 0, 0, 0, 1);
        check("overflow_data_kept", DATA_OUT, 8'h5A);
        check("overflow_flag", OVERFLOW, 8'h01);
        do_ack();
        check("overflow_ack_clear", {RXRDY, OVERFLOW}, 8'h00);

        RX = 1'b0;
        wait_cyc(4 * TICK_DIV);
        RX = 1'b1;
        wait_cyc(2 * BIT_CYC);
        check("glitch_rejected", RXRDY, 8'h00);

        send_frame(8'h81, 1, 0, 0, 0, 0);
        check("stop0_data", DATA_OUT, 8'h81);
        check("stop0_framing_err", FRAMING_ERR, 8'h01);
        do_ack();
        send_frame(8'h42, 1, 0, 0, 0, 1);
        check("resync_42_data", DATA_OUT, 8'h42);
        check("resync_42_framing_ok", FRAMING_ERR, 8'h00);
        do_ack();

        chk_en    = 1'b0;
        BIT8      = 1'b1;
        PARITY_EN = 1'b0;
        RX        = 1'b0;
        wait_cyc(12 * BIT_CYC);
        RX = 1'b1;
        wait_cyc(12 * BIT_CYC);
        model_frame(8'h00, 1, 0, 0, 0, 0);
`ifndef UART_RX_BREAK_DETECT_EN
        // Line still low after the first frame is taken as a second start bit; that byte overflows.
        model_frame(8'hFF, 1, 0, 0, 0, 1);
`endif
        chk_en = 1'b1;
        wait_cyc(1);
`ifdef UART_RX_BREAK_DETECT_EN
        check("break_det", BREAK_DET, 8'h01);
        check("break_rxrdy", RXRDY, 8'h00);
`else
        check("break_as_zero_data", DATA_OUT, 8'h00);
        check("break_framing_err", FRAMING_ERR, 8'h01);
        check("break_det_tied", BREAK_DET, 8'h00);
`endif
        do_ack();

        send_frame(8'h77, 1, 0, 0, 0, 1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        chk_en  = 1'b0;
        RX      = 1'b1;
        PRESETN = 1'b0;
        wait_cyc(1);
        PRESETN = 1'b1;
        model_reset();
        check("midframe_reset_data", DATA_OUT, 8'h00);
        check("midframe_reset_rxrdy", RXRDY, 8'h00);
        chk_en = 1'b1;
        wait_cyc(12 * BIT_CYC);
        check("post_reset_quiet", {RXRDY, FRAMING_ERR, OVERFLOW}, 8'h00);

        chk_en = 1'b0;
        wait_cyc(1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
